// File: rtl/sync_gate_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sync_gate_responder
//  Description : Responder side of the Sync/Gate/Done handshake. Runs the
//                sync-wait, gate-wait and gate-timeout counters and returns
//                wait-complete pulses plus the one-hot previous-state vector.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_gate_responder #(
   parameter int WAIT_W    = 8,
   parameter int SYNC_WAIT = 4,
   parameter int GATE_WAIT = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic       gate,
   input  logic       done,
   output logic [4:0] prev_state,
   output logic       wc,
   output logic       wc0,
   output logic       done_ack,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SYNC_WAIT = 3'd1,
      S_GATE_ON   = 3'd2,
      S_GATE_WAIT = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   // Counters are loaded with N-1 so that completion happens on the N-th edge.
   localparam logic [WAIT_W-1:0] c_sync_load = WAIT_W'(SYNC_WAIT - 1);
   localparam logic [WAIT_W-1:0] c_gate_load = WAIT_W'(GATE_WAIT - 1);
   localparam logic [WAIT_W-1:0] c_tmo_last  = WAIT_W'(TIMEOUT - 1);

   state_t            r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic [WAIT_W-1:0] r_tmo;

   state_t            w_state_nxt;
   logic [WAIT_W-1:0] w_cnt_nxt;
   logic [WAIT_W-1:0] w_tmo_nxt;
   logic              w_err_nxt;
   logic              w_wc_nxt;
   logic              w_wc0_nxt;
   logic              w_ack_nxt;
   logic              w_restart;
   logic [4:0]        w_state_oh;

   // One-hot view of the current state; registered to form prev_state.
   always_comb begin
      w_state_oh = 5'd1 << r_state;
   end

   // Next-state, counter and flag logic; restart outranks every other exit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_err_nxt   = err;
      w_wc_nxt    = 1'b0;
      w_wc0_nxt   = 1'b0;
      w_ack_nxt   = 1'b0;
      w_restart   = sync && ((r_state == S_SYNC_WAIT) ||
                             (r_state == S_GATE_ON)   ||
                             (r_state == S_GATE_WAIT));

      if (w_restart) begin
         w_state_nxt = S_SYNC_WAIT;
         w_cnt_nxt   = c_sync_load;
         w_err_nxt   = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (sync) begin
                  w_state_nxt = S_SYNC_WAIT;
                  w_cnt_nxt   = c_sync_load;
                  w_err_nxt   = 1'b0;
               end
            end
            S_SYNC_WAIT: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end else begin
                  w_state_nxt = S_GATE_ON;
                  w_wc_nxt    = 1'b1;
                  w_tmo_nxt   = '0;
               end
            end
            S_GATE_ON: begin
               if (gate) begin
                  w_state_nxt = S_GATE_WAIT;
                  w_cnt_nxt   = c_gate_load;
               end else if (r_tmo >= c_tmo_last) begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_tmo_nxt = r_tmo + 1'b1;
               end
            end
            S_GATE_WAIT: begin
               // gate is deliberately ignored on the completing edge
               if (r_cnt == '0) begin
                  w_state_nxt = S_FINISH;
                  w_wc0_nxt   = 1'b1;
               end else if (!gate) begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            S_FINISH: begin
               if (done) begin
                  w_state_nxt = S_IDLE;
                  w_ack_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State, counters and all registered outputs; async reset cancels pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_tmo      <= '0;
         prev_state <= 5'b00001;
         wc         <= 1'b0;
         wc0        <= 1'b0;
         done_ack   <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_tmo      <= w_tmo_nxt;
         prev_state <= w_state_oh;
         wc         <= w_wc_nxt;
         wc0        <= w_wc0_nxt;
         done_ack   <= w_ack_nxt;
         busy       <= (w_state_nxt != S_IDLE);
         err        <= w_err_nxt;
      end
   end

endmodule
`default_nettype wire
